// File: rtl/alu_share_if.sv
// alu_share_if: request/grant/result bundle between two requesters, the
// shared-ALU arbiter and the shared miniALU. The arbiter takes the slave
// modport; the lab-side logic (requesters plus the ALU) takes the master modport.
// Optional per-requester transaction counters are present when
// ALU_ARB_CNT_EN is defined.
interface alu_share_if #(
  parameter int WIDTH = 4
);
  logic             req0, req1;
  logic [WIDTH-1:0] a0, a1;
  logic [WIDTH-1:0] b0, b1;
  logic             op0, op1;
  logic             gnt0, gnt1;
  logic             done0, done1;
  logic [WIDTH:0]   res0, res1;
  logic             busy;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_op;
  logic [WIDTH:0]   alu_result;
`ifdef ALU_ARB_CNT_EN
  logic             cnt_clr;
  logic [7:0]       cnt0, cnt1;

  modport master (
    output req0, req1, a0, a1, b0, b1, op0, op1, alu_result, cnt_clr,
    input  gnt0, gnt1, done0, done1, res0, res1, busy, alu_a, alu_b, alu_op,
           cnt0, cnt1
  );

  modport slave (
    input  req0, req1, a0, a1, b0, b1, op0, op1, alu_result, cnt_clr,
    output gnt0, gnt1, done0, done1, res0, res1, busy, alu_a, alu_b, alu_op,
           cnt0, cnt1
  );
`else
  modport master (
    output req0, req1, a0, a1, b0, b1, op0, op1, alu_result,
    input  gnt0, gnt1, done0, done1, res0, res1, busy, alu_a, alu_b, alu_op
  );

  modport slave (
    input  req0, req1, a0, a1, b0, b1, op0, op1, alu_result,
    output gnt0, gnt1, done0, done1, res0, res1, busy, alu_a, alu_b, alu_op
  );
`endif
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational miniALU between
// two requesters. The winner's operands are latched in IDLE, held on the ALU
// for SETTLE cycles (HOLD), the result is registered on the last HOLD edge
// and flagged with a one-cycle done in DONE. Service period is SETTLE+2.
// Optional macro ALU_ARB_CNT_EN adds 8-bit completed-transaction counters
// per requester with a synchronous clear (cnt_clr).
module alu_share_arbiter #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_share_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  // Counter value seen in the final HOLD cycle.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("alu_share_arbiter: SETTLE=%0d is outside 1..15", SETTLE);
    end
  endgenerate

  state_t           state_q, state_d;
  logic             win_q;       // id of the requester being served
  logic             last_q;      // id of the most recent winner
  logic [3:0]       cnt_q;       // HOLD cycle index
  logic             pick_vld;
  logic             pick;
  logic             last_hold;

  logic [WIDTH-1:0] a_p0, b_p0;
  logic             op_p0;
  logic [WIDTH:0]   res0_q, res1_q;

  logic             gnt0_c, gnt1_c, done0_c, done1_c;
  logic [WIDTH-1:0] alu_a_c, alu_b_c;
  logic             alu_op_c;

  assign last_hold = (state_q == HOLD) && (cnt_q == SETTLE_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, next state, handshake pulses and ALU drive.
  always_comb begin
    state_d  = state_q;
    pick_vld = 1'b0;
    pick     = 1'b0;
    gnt0_c   = 1'b0;
    gnt1_c   = 1'b0;
    done0_c  = 1'b0;
    done1_c  = 1'b0;
    alu_a_c  = '0;
    alu_b_c  = '0;
    alu_op_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          pick_vld = 1'b1;
          pick     = ~last_q;
        end else if (bus.req0) begin
          pick_vld = 1'b1;
          pick     = 1'b0;
        end else if (bus.req1) begin
          pick_vld = 1'b1;
          pick     = 1'b1;
        end
        if (pick_vld) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        alu_a_c  = a_p0;
        alu_b_c  = b_p0;
        alu_op_c = op_p0;
        if (cnt_q == 4'd0) begin
          gnt0_c = ~win_q;
          gnt1_c = win_q;
        end
        if (cnt_q == SETTLE_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        alu_a_c  = a_p0;
        alu_b_c  = b_p0;
        alu_op_c = op_p0;
        done0_c  = ~win_q;
        done1_c  = win_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Winner bookkeeping and HOLD cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= 1'b0;
      last_q <= 1'b1;
      cnt_q  <= 4'd0;
    end else begin
      if (pick_vld) begin
        win_q  <= pick;
        last_q <= pick;
      end
      if ((state_q == HOLD) && !last_hold) begin
        cnt_q <= cnt_q + 4'd1;
      end else begin
        cnt_q <= 4'd0;
      end
    end
  end

  // Operand latch: sampled only when a request is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (pick_vld) begin
      a_p0  <= pick ? bus.a1  : bus.a0;
      b_p0  <= pick ? bus.b1  : bus.b0;
      op_p0 <= pick ? bus.op1 : bus.op0;
    end
  end

  // Result capture into the winner's register on the last HOLD edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res0_q <= '0;
      res1_q <= '0;
    end else if (last_hold) begin
      if (win_q) begin
        res1_q <= bus.alu_result;
      end else begin
        res0_q <= bus.alu_result;
      end
    end
  end

  assign bus.gnt0   = gnt0_c;
  assign bus.gnt1   = gnt1_c;
  assign bus.done0  = done0_c;
  assign bus.done1  = done1_c;
  assign bus.res0   = res0_q;
  assign bus.res1   = res1_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.alu_a  = alu_a_c;
  assign bus.alu_b  = alu_b_c;
  assign bus.alu_op = alu_op_c;

`ifdef ALU_ARB_CNT_EN
  logic [7:0] cnt0_q, cnt1_q;

  // Completed-transaction counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else if (bus.cnt_clr) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      if (done0_c) begin
        cnt0_q <= cnt0_q + 8'd1;
      end
      if (done1_c) begin
        cnt1_q <= cnt1_q + 8'd1;
      end
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif

endmodule
